// File: rtl/pipeline_pkg.sv
// Shared definitions for the elastic valid/ready pipeline.
//   P_WIDTH  : default data word width in bits
//   P_STAGES : default number of register stages
//   data_t   : data word at the default width
package pipeline_pkg;

  localparam int P_WIDTH  = 32;
  localparam int P_STAGES = 3;

  typedef logic [P_WIDTH-1:0] data_t;

endpackage : pipeline_pkg

// File: rtl/pipeline_vr_stage.sv
// One elastic stage: a single valid/data register pair.
// The stage can take a new beat when it is empty or when its current beat
// leaves this cycle. Data loads only on a valid upstream beat, so the data
// register keeps its last value through bubbles.
//   i_clk, i_rst      : clock, synchronous active-high reset
//   i_valid, i_data   : upstream beat
//   i_ready           : downstream ready
//   o_ready           : this stage accepts a beat this cycle (combinational)
//   o_valid, o_data   : registered beat towards downstream
module pipeline_vr_stage
  import pipeline_pkg::*;
#(
  parameter int p_width = P_WIDTH
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  input  logic [p_width-1:0] i_data,
  input  logic               i_ready,
  output logic               o_ready,
  output logic               o_valid,
  output logic [p_width-1:0] o_data
);

  logic               valid_q, valid_d;
  logic [p_width-1:0] data_q, data_d;

  // Deliberately combinational: ready ripples straight back through the pipe.
  assign o_ready = !valid_q | i_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (o_ready) begin
      valid_d = i_valid;
      if (i_valid) begin
        data_d = i_data;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;

endmodule : pipeline_vr_stage

// File: rtl/pipeline_valid_ready.sv
// Elastic data pipeline of p_stages valid/ready register stages.
// Valid and data move forward one stage per cycle; ready is a purely
// combinational chain from the sink (i_ready) back to the source (o_ready).
//   i_clk, i_rst      : clock, synchronous active-high reset
//   i_valid, i_data   : source beat
//   o_ready           : pipeline accepts a beat this cycle
//   o_valid, o_data   : sink-side beat (last stage)
//   i_ready           : sink accepts a beat this cycle
module pipeline_valid_ready
  import pipeline_pkg::*;
#(
  parameter int p_width  = P_WIDTH,
  parameter int p_stages = P_STAGES
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [p_width-1:0] i_data,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [p_width-1:0] o_data
);

  // Index s is the input of stage s; index p_stages is the sink side.
  logic               vld [0:p_stages];
  logic [p_width-1:0] dat [0:p_stages];
  logic               rdy [0:p_stages];

  assign vld[0]        = i_valid;
  assign dat[0]        = i_data;
  assign rdy[p_stages] = i_ready;

  for (genvar s = 0; s < p_stages; s++) begin : g_stage
    pipeline_vr_stage #(
      .p_width(p_width)
    ) u_stage (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_valid(vld[s]),
      .i_data (dat[s]),
      .i_ready(rdy[s+1]),
      .o_ready(rdy[s]),
      .o_valid(vld[s+1]),
      .o_data (dat[s+1])
    );
  end

  assign o_ready = rdy[0];
  assign o_valid = vld[p_stages];
  assign o_data  = dat[p_stages];

endmodule : pipeline_valid_ready

// File: tb/tb_pipeline_valid_ready.sv
// Directed bench for the elastic pipeline (3 x 32 bit), plus a randomized
// scoreboard run on a 1 x 8 bit instance.
module tb_pipeline_valid_ready;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready, in_ready, out_valid;
  logic [31:0] in_data, out_data;

  logic        s_in_valid, s_out_ready, s_in_ready, s_out_valid;
  logic [7:0]  s_in_data, s_out_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipeline_valid_ready #(.p_width(32), .p_stages(3)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_valid(in_valid),
    .o_ready(out_ready),
    .i_data (in_data),
    .o_valid(out_valid),
    .i_ready(in_ready),
    .o_data (out_data)
  );

  pipeline_valid_ready #(.p_width(8), .p_stages(1)) dut_small (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_valid(s_in_valid),
    .o_ready(s_out_ready),
    .i_data (s_in_data),
    .o_valid(s_out_valid),
    .i_ready(s_in_ready),
    .o_data (s_out_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; outputs are then settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] sb_q[$];
  logic [7:0] next_val;
  int         received;
  int         cycles;

  initial begin
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_data     = '0;
    in_ready    = 1'b1;
    s_in_valid  = 1'b0;
    s_in_data   = '0;
    s_out_ready = 1'b0;
    s_in_ready  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;

    // Reset then idle
    for (int i = 0; i < 10; i++) begin
      check("idle_valid", {31'd0, out_valid}, 32'd0);
      check("idle_data",  out_data,           32'd0);
      check("idle_ready", {31'd0, out_ready}, 32'd1);
      tick();
    end

    // Single beat: output visible in the third cycle after the transfer
    in_valid = 1'b1;
    in_data  = 32'hDEADBEEF;
    #1;
    check("single_accept", {31'd0, out_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    in_data  = '0;
    check("single_c1_valid", {31'd0, out_valid}, 32'd0);
    tick();
    check("single_c2_valid", {31'd0, out_valid}, 32'd0);
    tick();
    check("single_c3_valid", {31'd0, out_valid}, 32'd1);
    check("single_c3_data",  out_data,           32'hDEADBEEF);
    tick();
    check("single_c4_valid", {31'd0, out_valid}, 32'd0);
    tick();

    // Stream 1..8 back to back, i_ready held high
    for (int j = 0; j < 14; j++) begin
      in_valid = (j < 8);
      in_data  = (j < 8) ? 32'(j + 1) : 32'd0;
      #1;
      check("stream_ready", {31'd0, out_ready}, 32'd1);
      check("stream_valid", {31'd0, out_valid}, (j >= 3 && j < 11) ? 32'd1 : 32'd0);
      if (j >= 3 && j < 11) check("stream_data", out_data, 32'(j - 2));
      tick();
    end
    in_valid = 1'b0;

    // Backpressure: sink stalled, offer 1,2,3,4
    in_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      in_valid = 1'b1;
      in_data  = 32'(k);
      #1;
      check("bp_fill_ready", {31'd0, out_ready}, 32'd1);
      tick();
    end
    in_data = 32'd4;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_stall_ready", {31'd0, out_ready}, 32'd0);
      check("bp_stall_valid", {31'd0, out_valid}, 32'd1);
      check("bp_stall_data",  out_data,           32'd1);
      tick();
    end
    in_ready = 1'b1;
    #1;
    check("bp_release_ready", {31'd0, out_ready}, 32'd1);
    check("bp_release_data",  out_data,           32'd1);
    tick();
    in_valid = 1'b0;
    in_data  = '0;
    for (int k = 2; k <= 4; k++) begin
      check("bp_drain_valid", {31'd0, out_valid}, 32'd1);
      check("bp_drain_data",  out_data,           32'(k));
      tick();
    end
    check("bp_empty_valid", {31'd0, out_valid}, 32'd0);
    tick();

    // Reset with two beats in flight
    in_valid = 1'b1;
    in_data  = 32'hA1;
    tick();
    in_data  = 32'hA2;
    tick();
    in_valid = 1'b0;
    in_data  = '0;
    rst      = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mid_data",  out_data,           32'd0);
    for (int k = 0; k < 6; k++) begin
      tick();
      check("rst_no_ghost", {31'd0, out_valid}, 32'd0);
    end

    // 1-stage, 8-bit instance: random handshakes against a scoreboard
    next_val = 8'd0;
    received = 0;
    cycles   = 0;
    while (received < 1000 && cycles < 20000) begin
      // A pending, unaccepted beat is held; otherwise maybe offer a new one.
      if (!s_in_valid) begin
        s_in_valid = ($urandom_range(0, 3) != 0);
        s_in_data  = next_val;
      end
      s_in_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (s_out_valid && s_in_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_beat", {31'd0, s_out_valid}, 32'd0);
        end else begin
          check("sb_order", {24'd0, s_out_data}, {24'd0, sb_q.pop_front()});
        end
        received++;
      end
      if (s_in_valid && s_out_ready) begin
        sb_q.push_back(s_in_data);
        next_val++;
        tick();
        s_in_valid = 1'b0;
      end else begin
        tick();
      end
      cycles++;
    end
    check("sb_completed_1000", 32'(received), 32'd1000);
    check("sb_backlog_small", {31'd0, (sb_q.size() <= 1)}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_pipeline_valid_ready
